// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: holds one renamed instruction, decodes its FU class and
// dispatches to the ALU/branch/LSU reservation station when it and the ROB
// have space. Also keeps the FU-availability scoreboard (fu_free) and
// sequences the post-mispredict flush window.
// Ports: clk, reset (sync, active-high); rename side in_valid/in_ready/Opcode;
//   rob_full, rs_full[2:0]; fu_issued/fu_done scoreboard pulses; mispredict;
//   outputs di_en (one-hot), fu_sel, rob_alloc, fu_free, illegal_op,
//   flushing, stall_cnt.
// Optional macro DISPATCH_PERF_EN: when defined, stall_cnt is a saturating
//   blocked-cycle counter; otherwise stall_cnt is tied to zero.
module dispatch_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned STALL_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         Opcode,
    input  logic               rob_full,
    input  logic [2:0]         rs_full,
    input  logic [2:0]         fu_issued,
    input  logic [2:0]         fu_done,
    input  logic               mispredict,
    output logic [2:0]         di_en,
    output logic [1:0]         fu_sel,
    output logic               rob_alloc,
    output logic [2:0]         fu_free,
    output logic               illegal_op,
    output logic               flushing,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

    localparam logic [3:0] FLUSH_LD = 4'(FLUSH_CYCLES);

    state_e     state_q;
    logic       slot_valid_q;
    logic [1:0] fu_sel_q;
    logic       illegal_q;
    logic [3:0] flush_cnt_q;
    logic [2:0] fu_free_q;
    logic [2:0] fu_free_d;

    logic       dec_legal;
    logic [1:0] dec_cls;
    logic       rs_blk;
    logic       in_flush;
    logic       fire;
    logic       accept;

    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = 2'd0;
        case (Opcode)
            7'b0110011, 7'b0010011,
            7'b0110111, 7'b0010111: dec_cls = 2'd0;
            7'b1100011, 7'b1101111,
            7'b1100111:             dec_cls = 2'd1;
            7'b0000011, 7'b0100011: dec_cls = 2'd2;
            default: begin
                dec_legal = 1'b0;
                dec_cls   = 2'd0;
            end
        endcase
    end

    always_comb begin
        rs_blk = 1'b1;
        case (fu_sel_q)
            2'd0:    rs_blk = rs_full[0];
            2'd1:    rs_blk = rs_full[1];
            2'd2:    rs_blk = rs_full[2];
            default: rs_blk = 1'b1;
        endcase
    end

    assign in_flush = (state_q == FLUSH);

    // Mispredict kills both the dispatch and the accept of this cycle.
    assign fire = slot_valid_q & ~rs_blk & ~rob_full
                & ~in_flush & ~mispredict;
    assign in_ready = ~in_flush & ~mispredict
                    & (~slot_valid_q | fire);
    assign accept = in_valid & in_ready;

    assign di_en      = fire ? (3'b001 << fu_sel_q) : 3'b000;
    assign rob_alloc  = fire;
    assign fu_sel     = fu_sel_q;
    assign fu_free    = fu_free_q;
    assign illegal_op = illegal_q;
    assign flushing   = in_flush;

    // Issue wins over done when both pulse for the same FU.
    assign fu_free_d = (fu_free_q | fu_done) & ~fu_issued;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            slot_valid_q <= 1'b0;
            fu_sel_q     <= 2'd0;
            illegal_q    <= 1'b0;
            flush_cnt_q  <= 4'd0;
            fu_free_q    <= 3'b111;
        end else begin
            fu_free_q <= fu_free_d;
            illegal_q <= accept & ~dec_legal;
            if (mispredict) begin
                state_q      <= FLUSH;
                flush_cnt_q  <= FLUSH_LD;
                slot_valid_q <= 1'b0;
            end else if (in_flush) begin
                flush_cnt_q <= flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) begin
                    state_q <= RUN;
                end
            end else begin
                state_q <= (slot_valid_q & ~fire) ? STALL : RUN;
                if (accept & dec_legal) begin
                    slot_valid_q <= 1'b1;
                    fu_sel_q     <= dec_cls;
                end else if (fire) begin
                    slot_valid_q <= 1'b0;
                end
            end
        end
    end

`ifdef DISPATCH_PERF_EN
    logic [STALL_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (slot_valid_q & ~fire & ~in_flush & ~(&stall_q)) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed scenarios plus randomized traffic for
// dispatch_ctrl, checked every cycle against a slot/queue reference model.
module tb_dispatch_ctrl;

    localparam int FC   = 2;
    localparam int SW   = 4;
    localparam int MAXS = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    Opcode;
    logic          rob_full;
    logic [2:0]    rs_full;
    logic [2:0]    fu_issued;
    logic [2:0]    fu_done;
    logic          mispredict;
    logic [2:0]    di_en;
    logic [1:0]    fu_sel;
    logic          rob_alloc;
    logic [2:0]    fu_free;
    logic          illegal_op;
    logic          flushing;
    logic [SW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    dispatch_ctrl #(
        .FLUSH_CYCLES(FC),
        .STALL_W     (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Opcode     (Opcode),
        .rob_full   (rob_full),
        .rs_full    (rs_full),
        .fu_issued  (fu_issued),
        .fu_done    (fu_done),
        .mispredict (mispredict),
        .di_en      (di_en),
        .fu_sel     (fu_sel),
        .rob_alloc  (rob_alloc),
        .fu_free    (fu_free),
        .illegal_op (illegal_op),
        .flushing   (flushing),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a queue holding at most one FU class, remaining
    // flush cycles, per-FU free flags and a blocked-cycle tally.
    int q_slot[$];
    int m_cls;
    int m_flush_left;
    bit m_free[3];
    int m_stall;
    bit m_ill;

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: return 0;
            7'b1100011, 7'b1101111, 7'b1100111:             return 1;
            7'b0000011, 7'b0100011:                         return 2;
            default:                                        return -1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_slot.delete();
        m_cls        = 0;
        m_flush_left = 0;
        m_free       = '{1, 1, 1};
        m_stall      = 0;
        m_ill        = 0;
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [6:0] op,
                       input logic [2:0] rsf, input bit robf,
                       input logic [2:0] iss, input logic [2:0] dn,
                       input bit mp);
        bit fl, fire, rdy, acc;
        int c;
        logic [2:0] e_di;
        @(negedge clk);
        reset      = rst;
        in_valid   = v;
        Opcode     = op;
        rs_full    = rsf;
        rob_full   = robf;
        fu_issued  = iss;
        fu_done    = dn;
        mispredict = mp;
        #1;
        fl   = (m_flush_left > 0);
        fire = (q_slot.size() == 1) && !rsf[q_slot[0]] && !robf
               && !fl && !mp;
        rdy  = !fl && !mp && ((q_slot.size() == 0) || fire);
        e_di = fire ? 3'(1 << q_slot[0]) : 3'b000;
        if (!rst) begin
            chk("di_en", 32'(di_en), 32'(e_di));
            chk("in_ready", 32'(in_ready), 32'(rdy));
            chk("rob_alloc", 32'(rob_alloc), 32'(fire));
            chk("fu_sel", 32'(fu_sel), 32'(m_cls));
            chk("fu_free", 32'(fu_free),
                32'({m_free[2], m_free[1], m_free[0]}));
            chk("illegal_op", 32'(illegal_op), 32'(m_ill));
            chk("flushing", 32'(flushing), 32'(fl));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            acc = v && rdy;
            c   = cls_of(op);
`ifdef DISPATCH_PERF_EN
            if ((q_slot.size() == 1) && !fire && !fl && m_stall < MAXS)
                m_stall++;
`endif
            if (mp) begin
                q_slot.delete();
                m_flush_left = FC;
            end else if (fl) begin
                m_flush_left--;
            end else if (acc && c >= 0) begin
                q_slot.delete();
                q_slot.push_back(c);
                m_cls = c;
            end else if (fire) begin
                void'(q_slot.pop_front());
            end
            m_ill = acc && (c < 0);
            for (int i = 0; i < 3; i++) begin
                if (iss[i])     m_free[i] = 0;
                else if (dn[i]) m_free[i] = 1;
            end
        end
    endtask

    task automatic idle(input int n, input logic [2:0] rsf);
        for (int i = 0; i < n; i++)
            cyc(0, 0, 7'h00, rsf, 0, 3'b000, 3'b000, 0);
    endtask

    logic [6:0] legal_ops [9] = '{
        7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
        7'b1100011, 7'b1101111, 7'b1100111,
        7'b0000011, 7'b0100011
    };

    initial begin
        model_reset();
        reset = 1'b1; in_valid = 1'b0; Opcode = '0; rob_full = 1'b0;
        rs_full = '0; fu_issued = '0; fu_done = '0; mispredict = 1'b0;
        cyc(1, 0, 7'h00, 3'b000, 0, 3'b000, 3'b000, 0);
        cyc(1, 1, 7'b0110011, 3'b000, 0, 3'b000, 3'b000, 1);
        idle(1, 3'b000);

        // ALU op dispatches the cycle after acceptance
        cyc(0, 1, 7'b0110011, 3'b000, 0, 3'b000, 3'b000, 0);
        idle(2, 3'b000);

        // load blocked by a full LSU station, then released
        cyc(0, 1, 7'b0000011, 3'b000, 0, 3'b000, 3'b000, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 7'b0110011, 3'b100, 0, 3'b000, 3'b000, 0);
        cyc(0, 0, 7'h00, 3'b000, 0, 3'b000, 3'b000, 0);
        idle(2, 3'b000);

        // mispredict drops a waiting branch op and opens the flush window
        cyc(0, 1, 7'b1100011, 3'b000, 0, 3'b000, 3'b000, 0);
        cyc(0, 1, 7'b0110011, 3'b010, 0, 3'b000, 3'b000, 1);
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 7'h00, 3'b000, 0, 3'b000, 3'b000, 0);

        // mispredict inside the flush window restarts it
        cyc(0, 0, 7'h00, 3'b000, 0, 3'b000, 3'b000, 1);
        cyc(0, 1, 7'b0110011, 3'b000, 0, 3'b000, 3'b000, 1);
        idle(4, 3'b000);

        // undecodable opcode is swallowed
        cyc(0, 1, 7'b1111111, 3'b000, 0, 3'b000, 3'b000, 0);
        idle(3, 3'b000);

        // scoreboard: issue clears, issue beats done, done sets
        cyc(0, 0, 7'h00, 3'b000, 0, 3'b010, 3'b000, 0);
        cyc(0, 0, 7'h00, 3'b000, 0, 3'b010, 3'b010, 0);
        cyc(0, 0, 7'h00, 3'b000, 0, 3'b000, 3'b010, 0);
        idle(1, 3'b000);

        // long stall to reach the counter ceiling; ROB full also blocks
        cyc(0, 1, 7'b0100011, 3'b000, 0, 3'b000, 3'b000, 0);
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 7'h00, 3'b000, 1, 3'b000, 3'b000, 0);
        idle(2, 3'b000);

        // back-to-back ALU stream, then reset mid-stream
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 7'b0010011, 3'b000, 0, 3'b101, 3'b000, 0);
        cyc(1, 1, 7'b0010011, 3'b000, 0, 3'b000, 3'b000, 0);
        idle(3, 3'b000);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            logic [2:0] rsf;
            op  = legal_ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = 7'($urandom);
            rsf = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000;
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 3) != 0, op, rsf,
                $urandom_range(0, 5) == 0,
                3'($urandom) & 3'($urandom),
                3'($urandom),
                $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
